// File: rtl/pc_seq.sv
// Multi-cycle fetch/decode/execute sequencer owning the architectural PC and instret.
// Optional feature: define PC_MISALIGN_TRAP_EN to trap on a misaligned committed PC.
module pc_seq #(
    parameter int                   CPU_WIDTH = 32,
    parameter logic [CPU_WIDTH-1:0] RESET_PC  = 32'h8000_0000,
    parameter int                   INSTRET_W = 64
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    output logic                 o_ifu_req_valid,
    output logic [CPU_WIDTH-1:0] o_ifu_req_addr,
    input  logic                 i_ifu_req_ready,
    input  logic                 i_ifu_rsp_valid,
    input  logic [31:0]          i_ifu_rsp_inst,
    output logic                 o_idu_valid,
    output logic [31:0]          o_idu_inst,
    output logic [CPU_WIDTH-1:0] o_ifu_pc,
    input  logic [CPU_WIDTH-1:0] i_bru_next_pc,
    input  logic                 i_exu_done,
    input  logic                 i_halt,
    output logic                 o_commit,
    output logic                 o_halted,
    output logic [INSTRET_W-1:0] o_instret,
    output logic                 o_misalign
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT_RSP,
        S_EXEC,
        S_HALT
`ifdef PC_MISALIGN_TRAP_EN
        , S_TRAP
`endif
    } state_t;

    state_t                 state;
    logic [CPU_WIDTH-1:0]   pc;
    logic [INSTRET_W-1:0]   instret;
    logic                   req_valid;
    logic                   idu_valid;
    logic                   halted;
    logic                   misalign;
    logic [31:0]            inst;

    localparam logic [INSTRET_W-1:0] INSTRET_ONE = {{(INSTRET_W-1){1'b0}}, 1'b1};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= S_IDLE;
            pc        <= RESET_PC;
            inst      <= 32'h0;
            instret   <= '0;
            req_valid <= 1'b0;
            idu_valid <= 1'b0;
            halted    <= 1'b0;
            misalign  <= 1'b0;
        end else begin
            idu_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    state     <= S_FETCH;
                    req_valid <= 1'b1;
                end
                S_FETCH: begin
                    if (i_ifu_req_ready) begin
                        state     <= S_WAIT_RSP;
                        req_valid <= 1'b0;
                    end
                end
                S_WAIT_RSP: begin
                    if (i_ifu_rsp_valid) begin
                        inst      <= i_ifu_rsp_inst;
                        state     <= S_EXEC;
                        idu_valid <= 1'b1;
                    end
                end
                S_EXEC: begin
                    if (i_exu_done) begin
                        instret <= instret + INSTRET_ONE;
                        if (i_halt) begin
                            // PC stays on the halting instruction
                            state  <= S_HALT;
                            halted <= 1'b1;
                        end else begin
`ifdef PC_MISALIGN_TRAP_EN
                            pc <= i_bru_next_pc;
                            if (i_bru_next_pc[1:0] != 2'b00) begin
                                state    <= S_TRAP;
                                halted   <= 1'b1;
                                misalign <= 1'b1;
                            end else begin
                                state     <= S_FETCH;
                                req_valid <= 1'b1;
                            end
`else
                            pc        <= {i_bru_next_pc[CPU_WIDTH-1:2], 2'b00};
                            state     <= S_FETCH;
                            req_valid <= 1'b1;
`endif
                        end
                    end
                end
                default: ; // HALT / TRAP absorb until reset
            endcase
        end
    end

`ifndef PC_MISALIGN_TRAP_EN
    logic unused_misalign_tie;
    assign unused_misalign_tie = misalign;
`endif

    assign o_ifu_req_valid = req_valid;
    assign o_ifu_req_addr  = pc;
    assign o_ifu_pc        = pc;
    assign o_idu_valid     = idu_valid;
    assign o_idu_inst      = inst;
    assign o_commit        = (state == S_EXEC) && i_exu_done;
    assign o_halted        = halted;
    assign o_instret       = instret;
`ifdef PC_MISALIGN_TRAP_EN
    assign o_misalign      = misalign;
`else
    assign o_misalign      = 1'b0;
`endif

endmodule

// File: tb/tb_pc_seq.sv
// Directed self-checking bench for pc_seq.
module tb_pc_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_inst;
    logic        idu_valid;
    logic [31:0] idu_inst;
    logic [31:0] ifu_pc;
    logic [31:0] next_pc;
    logic        exu_done;
    logic        halt;
    logic        commit;
    logic        halted;
    logic [63:0] instret;
    logic        misalign;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pc_seq dut (
        .i_clk(clk), .i_rst(rst),
        .o_ifu_req_valid(req_valid), .o_ifu_req_addr(req_addr),
        .i_ifu_req_ready(req_ready), .i_ifu_rsp_valid(rsp_valid),
        .i_ifu_rsp_inst(rsp_inst), .o_idu_valid(idu_valid),
        .o_idu_inst(idu_inst), .o_ifu_pc(ifu_pc),
        .i_bru_next_pc(next_pc), .i_exu_done(exu_done), .i_halt(halt),
        .o_commit(commit), .o_halted(halted), .o_instret(instret),
        .o_misalign(misalign)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // From FETCH: accept at once, respond one cycle later; ends in first EXEC cycle.
    task automatic run_fetch(input logic [31:0] inst);
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        rsp_valid = 1'b1;
        rsp_inst  = inst;
        tick();
        rsp_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_ready = 0; rsp_valid = 0; rsp_inst = 0;
        next_pc = 0; exu_done = 0; halt = 0;
        tick(); tick();
        n_cmp++;
        if ({req_valid, idu_valid, commit, halted, misalign} !== 5'b0) begin
            n_err++; $display("FAIL reset_flags got %b exp 00000", {req_valid, idu_valid, commit, halted, misalign});
        end
        n_cmp++;
        if (instret !== 64'd0 || idu_inst !== 32'd0) begin
            n_err++; $display("FAIL reset_regs instret=%0d inst=%h exp 0/0", instret, idu_inst);
        end
        n_cmp++;
        if (ifu_pc !== 32'h8000_0000) begin
            n_err++; $display("FAIL reset_pc got %h exp 80000000", ifu_pc);
        end
        rst = 1'b0;
        tick();
        n_cmp++;
        if (req_valid !== 1'b1 || req_addr !== 32'h8000_0000) begin
            n_err++; $display("FAIL first_req valid=%b addr=%h exp 1/80000000", req_valid, req_addr);
        end
    endtask

    task automatic test_basic();
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        n_cmp++;
        if (req_valid !== 1'b0) begin
            n_err++; $display("FAIL basic_wait_req got %b exp 0", req_valid);
        end
        rsp_valid = 1'b1; rsp_inst = 32'h0000_0013;
        tick();
        rsp_valid = 1'b0;
        n_cmp++;
        if (idu_valid !== 1'b1 || idu_inst !== 32'h0000_0013) begin
            n_err++; $display("FAIL basic_decode valid=%b inst=%h exp 1/00000013", idu_valid, idu_inst);
        end
        exu_done = 1'b1; next_pc = 32'h8000_0004;
        #1;
        n_cmp++;
        if (commit !== 1'b1) begin
            n_err++; $display("FAIL basic_commit got %b exp 1", commit);
        end
        tick();
        exu_done = 1'b0;
        n_cmp++;
        if (req_valid !== 1'b1 || req_addr !== 32'h8000_0004 || instret !== 64'd1 || commit !== 1'b0) begin
            n_err++; $display("FAIL basic_next valid=%b addr=%h instret=%0d commit=%b exp 1/80000004/1/0",
                              req_valid, req_addr, instret, commit);
        end
    endtask

    task automatic test_stall();
        int bad = 0;
        req_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (req_valid !== 1'b1 || req_addr !== 32'h8000_0004) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++; $display("FAIL stall_hold bad_cycles got %0d exp 0", bad);
        end
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        n_cmp++;
        if (req_valid !== 1'b0) begin
            n_err++; $display("FAIL stall_accept req_valid got %b exp 0", req_valid);
        end
        rsp_valid = 1'b1; rsp_inst = 32'h0040_0093;
        tick();
        rsp_valid = 1'b0;
        n_cmp++;
        if (idu_valid !== 1'b1 || idu_inst !== 32'h0040_0093) begin
            n_err++; $display("FAIL stall_one_wait valid=%b inst=%h exp 1/00400093", idu_valid, idu_inst);
        end
        exu_done = 1'b1; next_pc = 32'h8000_0008;
        tick();
        exu_done = 1'b0;
        n_cmp++;
        if (req_addr !== 32'h8000_0008 || instret !== 64'd2) begin
            n_err++; $display("FAIL stall_next addr=%h instret=%0d exp 80000008/2", req_addr, instret);
        end
    endtask

    task automatic test_jump();
        int pulses = 0;
        int commits = 0;
        run_fetch(32'h0ff0_006f);
        if (idu_valid === 1'b1) pulses++;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (idu_valid === 1'b1) pulses++;
            if (commit === 1'b1) commits++;
        end
        exu_done = 1'b1; next_pc = 32'h8000_0100;
        #1;
        n_cmp++;
        if (commit !== 1'b1 || commits != 0) begin
            n_err++; $display("FAIL jump_commit commit=%b early=%0d exp 1/0", commit, commits);
        end
        tick();
        exu_done = 1'b0;
        n_cmp++;
        if (pulses != 1) begin
            n_err++; $display("FAIL jump_idu_pulses got %0d exp 1", pulses);
        end
        n_cmp++;
        if (req_valid !== 1'b1 || req_addr !== 32'h8000_0100 || instret !== 64'd3) begin
            n_err++; $display("FAIL jump_target valid=%b addr=%h instret=%0d exp 1/80000100/3",
                              req_valid, req_addr, instret);
        end
    endtask

    task automatic test_halt();
        int activity = 0;
        run_fetch(32'h0010_0073);
        exu_done = 1'b1; halt = 1'b1; next_pc = 32'h8000_0104;
        #1;
        n_cmp++;
        if (commit !== 1'b1) begin
            n_err++; $display("FAIL halt_commit got %b exp 1", commit);
        end
        tick();
        exu_done = 1'b0; halt = 1'b0;
        n_cmp++;
        if (halted !== 1'b1 || instret !== 64'd4 || ifu_pc !== 32'h8000_0100) begin
            n_err++; $display("FAIL halt_state halted=%b instret=%0d pc=%h exp 1/4/80000100",
                              halted, instret, ifu_pc);
        end
        for (int i = 0; i < 20; i++) begin
            exu_done  = i[0];
            rsp_valid = ~i[0];
            req_ready = 1'b1;
            #1;
            if (req_valid || idu_valid || commit) activity++;
            tick();
        end
        exu_done = 0; rsp_valid = 0; req_ready = 0;
        n_cmp++;
        if (activity != 0 || instret !== 64'd4 || halted !== 1'b1) begin
            n_err++; $display("FAIL halt_absorb activity=%0d instret=%0d halted=%b exp 0/4/1",
                              activity, instret, halted);
        end
    endtask

    task automatic test_reset_mid();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0; rsp_valid = 1'b1; rsp_inst = 32'hdead_beef;
        tick();
        n_cmp++;
        if (req_valid !== 1'b1 || req_addr !== 32'h8000_0000 || instret !== 64'd0 ||
            idu_inst !== 32'd0 || halted !== 1'b0) begin
            n_err++; $display("FAIL reset_mid valid=%b addr=%h instret=%0d inst=%h halted=%b exp 1/80000000/0/0/0",
                              req_valid, req_addr, instret, idu_inst, halted);
        end
        tick();
        rsp_valid = 1'b0;
        n_cmp++;
        if (req_valid !== 1'b1 || idu_valid !== 1'b0 || idu_inst !== 32'd0) begin
            n_err++; $display("FAIL rsp_in_fetch valid=%b idu_valid=%b inst=%h exp 1/0/0",
                              req_valid, idu_valid, idu_inst);
        end
    endtask

    task automatic test_misalign();
        run_fetch(32'h0000_0013);
        exu_done = 1'b1; next_pc = 32'h8000_0102;
        tick();
        exu_done = 1'b0;
        n_cmp++;
        if (instret !== 64'd1) begin
            n_err++; $display("FAIL misalign_instret got %0d exp 1", instret);
        end
`ifdef PC_MISALIGN_TRAP_EN
        n_cmp++;
        if (misalign !== 1'b1 || halted !== 1'b1 || req_valid !== 1'b0 || ifu_pc !== 32'h8000_0102) begin
            n_err++; $display("FAIL misalign_trap mis=%b halted=%b req=%b pc=%h exp 1/1/0/80000102",
                              misalign, halted, req_valid, ifu_pc);
        end
        req_ready = 1'b1;
        tick(); tick();
        req_ready = 1'b0;
        n_cmp++;
        if (req_valid !== 1'b0 || misalign !== 1'b1) begin
            n_err++; $display("FAIL misalign_absorb req=%b mis=%b exp 0/1", req_valid, misalign);
        end
`else
        n_cmp++;
        if (misalign !== 1'b0 || halted !== 1'b0 || req_valid !== 1'b1 || req_addr !== 32'h8000_0100) begin
            n_err++; $display("FAIL misalign_align mis=%b halted=%b req=%b addr=%h exp 0/0/1/80000100",
                              misalign, halted, req_valid, req_addr);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_jump();
        test_halt();
        test_reset_mid();
        test_misalign();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
